// File: rtl/onewire_seq_ctrl_pkg.sv
// Shared constants, types and the serial Dallas CRC-8 step for the 1-Wire sequencing controller.
package onewire_pkg;

    localparam logic [2:0] CMD_IDLE     = 3'b000;
    localparam logic [2:0] CMD_RESET    = 3'b010;
    localparam logic [2:0] CMD_PRES     = 3'b011;
    localparam logic [2:0] CMD_READ_ROM = 3'b100;
    localparam logic [2:0] CMD_SEND_ROM = 3'b101;

    localparam int ST_DONE = 0;
    localparam int ST_PRES = 1;

    // Reflected form of x^8+x^5+x^4+1
    localparam logic [7:0] CRC_POLY = 8'h8C;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NO_PRES = 2'b01,
        ERR_CRC     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_PRES,
        S_ROM,
        S_GAP,
        S_CRC,
        S_FIN
    } state_e;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb        = crc[0] ^ bit_in;
        crc8_step = (crc >> 1) ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    function automatic logic [2:0] phase_cmd(input state_e s);
        case (s)
            S_RST:   phase_cmd = CMD_RESET;
            S_PRES:  phase_cmd = CMD_PRES;
            S_ROM:   phase_cmd = CMD_READ_ROM;
            default: phase_cmd = CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/onewire_seq_ctrl_if.sv
// Host handshake plus 1-Wire master command bus, seen from the controller (slave) and its peers (master).
interface onewire_seq_ctrl_if;

    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [63:0] rom_id;
    logic [2:0]  m_cmd;
    logic [7:0]  m_din;
    logic [63:0] m_dout;
    logic [7:0]  m_status;

    modport slave (
        input  start, m_dout, m_status,
        output busy, done, err, rom_id, m_cmd, m_din
    );

    modport master (
        output start, m_dout, m_status,
        input  busy, done, err, rom_id, m_cmd, m_din
    );

endinterface

// File: rtl/onewire_seq_ctrl_crc8.sv
// Bit-serial Dallas CRC-8: one data bit per enabled cycle, clear has priority over enable.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= 8'h00;
        end else if (clr) begin
            crc_q <= 8'h00;
        end else if (en) begin
            crc_q <= crc8_step(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/onewire_seq_ctrl.sv
// Runs RESET -> PRESENCE -> READ_ROM on the 1-Wire master, CRC-checks the ROM and retries failed attempts.
module onewire_seq_ctrl
    import onewire_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int RETRIES     = 3,
    parameter int CNT_W       = 13
) (
    input logic               clk,
    input logic               rst,
    onewire_seq_ctrl_if.slave bus
);

    localparam int                RW        = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [5:0]       CRC_BITS  = 6'd56;

    state_e            state_q;
    state_e            gap_next_q;
    logic [RW-1:0]     retry_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic [5:0]        crc_bits_q;
    logic [63:0]       rom_buf_q;
    logic [63:0]       rom_id_q;
    logic              busy_q;
    logic              done_q;
    err_e              err_q;
    logic [2:0]        m_cmd_q;

    logic              ph_done_d;
    logic              ph_pres_d;
    logic              tmo_hit_d;
    logic              crc_ok_d;
    logic              fail_d;
    err_e              fail_code_d;
    logic              crc_clr_d;
    logic              crc_en_d;
    logic              crc_bit_d;
    logic [7:0]        crc_val;
    logic              unused_status;

    assign ph_done_d     = bus.m_status[ST_DONE];
    assign ph_pres_d     = bus.m_status[ST_PRES];
    assign tmo_hit_d     = (tmo_cnt_q == TMO_LAST);
    assign crc_ok_d      = (crc_val == rom_buf_q[63:56]);
    assign unused_status = ^bus.m_status[7:2];

    // The CRC engine is held cleared outside CRC so it starts from zero on every attempt.
    assign crc_clr_d = (state_q != S_CRC);
    assign crc_en_d  = (state_q == S_CRC) && (crc_bits_q != CRC_BITS);
    assign crc_bit_d = rom_buf_q[crc_bits_q];

    onewire_crc8 u_crc8 (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr_d),
        .en     (crc_en_d),
        .bit_in (crc_bit_d),
        .crc    (crc_val)
    );

    always_comb begin
        fail_d      = 1'b0;
        fail_code_d = ERR_OK;
        case (state_q)
            S_RST, S_ROM: begin
                if (!ph_done_d && tmo_hit_d) begin
                    fail_d      = 1'b1;
                    fail_code_d = ERR_TIMEOUT;
                end
            end
            S_PRES: begin
                if (ph_done_d && !ph_pres_d) begin
                    fail_d      = 1'b1;
                    fail_code_d = ERR_NO_PRES;
                end else if (!ph_done_d && tmo_hit_d) begin
                    fail_d      = 1'b1;
                    fail_code_d = ERR_TIMEOUT;
                end
            end
            S_CRC: begin
                if ((crc_bits_q == CRC_BITS) && !crc_ok_d) begin
                    fail_d      = 1'b1;
                    fail_code_d = ERR_CRC;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gap_next_q <= S_IDLE;
            retry_q    <= '0;
            tmo_cnt_q  <= '0;
            crc_bits_q <= '0;
            rom_buf_q  <= '0;
            rom_id_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_OK;
            m_cmd_q    <= CMD_IDLE;
        end else begin
            done_q <= 1'b0;
            if (fail_d) begin
                m_cmd_q <= CMD_IDLE;
                if (retry_q != '0) begin
                    retry_q    <= retry_q - RW'(1);
                    state_q    <= S_GAP;
                    gap_next_q <= S_RST;
                end else begin
                    state_q <= S_FIN;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= fail_code_d;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            retry_q   <= RW'(RETRIES);
                            busy_q    <= 1'b1;
                            err_q     <= ERR_OK;
                            tmo_cnt_q <= '0;
                            m_cmd_q   <= CMD_RESET;
                            state_q   <= S_RST;
                        end
                    end
                    S_RST, S_PRES, S_ROM: begin
                        if (ph_done_d) begin
                            if (state_q == S_ROM) begin
                                rom_buf_q <= bus.m_dout;
                            end
                            gap_next_q <= (state_q == S_RST)  ? S_PRES :
                                          (state_q == S_PRES) ? S_ROM  : S_CRC;
                            m_cmd_q    <= CMD_IDLE;
                            state_q    <= S_GAP;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                        end
                    end
                    // One idle-command cycle so the master sees a fresh command edge
                    S_GAP: begin
                        state_q    <= gap_next_q;
                        m_cmd_q    <= phase_cmd(gap_next_q);
                        tmo_cnt_q  <= '0;
                        crc_bits_q <= '0;
                    end
                    S_CRC: begin
                        if (crc_bits_q == CRC_BITS) begin
                            rom_id_q <= rom_buf_q;
                            state_q  <= S_FIN;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            err_q    <= ERR_OK;
                        end else begin
                            crc_bits_q <= crc_bits_q + 6'd1;
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        m_cmd_q <= CMD_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.rom_id = rom_id_q;
    assign bus.m_cmd  = m_cmd_q;
    assign bus.m_din  = 8'h00;

endmodule

// File: tb/tb_onewire_seq_ctrl.sv
// Self-checking bench: behavioural 1-Wire master per DUT, scoreboard of expected (err, rom_id) per sequence.
module tb_onewire_seq_ctrl;
    import onewire_pkg::*;

    localparam logic [63:0] ROM_GOOD = 64'hA200_0000_01B8_1C02;
    localparam logic [63:0] ROM_BAD  = 64'hA300_0000_01B8_1C02;

    typedef struct {
        logic [1:0]  err;
        logic [63:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    onewire_seq_ctrl_if bus_a ();
    onewire_seq_ctrl_if bus_b ();

    onewire_seq_ctrl #(.TIMEOUT_CYC(4096), .RETRIES(3), .CNT_W(13)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    onewire_seq_ctrl #(.TIMEOUT_CYC(16), .RETRIES(0), .CNT_W(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Behavioural masters: done one cycle after a command, cleared on idle command.
    logic        pres_a      = 1'b1;
    logic        done_a;
    logic [63:0] dout_a;
    logic [63:0] rom_first_a = ROM_GOOD;
    logic [63:0] rom_rest_a  = ROM_GOOD;
    int          rom_reads_a = 0;
    int          rom_base_a  = 0;
    logic        hang_b      = 1'b0;
    logic        done_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_a <= 1'b0;
            dout_a <= '0;
        end else if (bus_a.m_cmd == CMD_IDLE) begin
            done_a <= 1'b0;
        end else if (!done_a) begin
            done_a <= 1'b1;
            if (bus_a.m_cmd == CMD_READ_ROM) begin
                dout_a      <= (rom_reads_a == rom_base_a) ? rom_first_a : rom_rest_a;
                rom_reads_a <= rom_reads_a + 1;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_b <= 1'b0;
        end else if (bus_b.m_cmd == CMD_IDLE) begin
            done_b <= 1'b0;
        end else if (!(hang_b && bus_b.m_cmd == CMD_READ_ROM)) begin
            done_b <= 1'b1;
        end
    end

    assign bus_a.m_status = {6'b0, pres_a, done_a};
    assign bus_a.m_dout   = dout_a;
    assign bus_b.m_status = {6'b0, 1'b1, done_b};
    assign bus_b.m_dout   = ROM_GOOD;

    // Monitor for dut_a: command-change log, RESET phase count, done pulse count.
    logic [2:0] prev_cmd_a = CMD_IDLE;
    logic [2:0] cmd_log_a[$];
    int         rst_phases_a = 0;
    int         done_cnt_a   = 0;

    always @(negedge clk) begin
        if (bus_a.m_cmd != prev_cmd_a) begin
            cmd_log_a.push_back(bus_a.m_cmd);
            if (bus_a.m_cmd == CMD_RESET) rst_phases_a <= rst_phases_a + 1;
        end
        prev_cmd_a <= bus_a.m_cmd;
        if (bus_a.done === 1'b1) done_cnt_a <= done_cnt_a + 1;
    end

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   total = 0;
    int   bad   = 0;

    task automatic pulse_start_a();
        @(negedge clk) bus_a.start = 1'b1;
        @(negedge clk) bus_a.start = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk) bus_b.start = 1'b1;
        @(negedge clk) bus_b.start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cmd_a(input logic [2:0] c, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.m_cmd === c) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus_a.done); end
        total++; if (bus_a.err !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", bus_a.err); end
        total++; if (bus_a.rom_id !== 64'h0) begin bad++; $display("FAIL reset_rom_id: got %h want 0", bus_a.rom_id); end
        total++; if (bus_a.m_cmd !== 3'b000) begin bad++; $display("FAIL reset_m_cmd: got %b want 000", bus_a.m_cmd); end
        total++; if (bus_a.m_din !== 8'h00) begin bad++; $display("FAIL reset_m_din: got %h want 00", bus_a.m_din); end
        total++; if (bus_b.m_cmd !== 3'b000) begin bad++; $display("FAIL reset_b_m_cmd: got %b want 000", bus_b.m_cmd); end
        $display("reset: busy=%b done=%b err=%b rom_id=%h m_cmd=%b", bus_a.busy, bus_a.done, bus_a.err, bus_a.rom_id, bus_a.m_cmd);
    endtask

    task automatic test_no_presence();
        bit   seen;
        int   rst_base, dn_base;
        exp_t e;
        pres_a   = 1'b0;
        rst_base = rst_phases_a;
        dn_base  = done_cnt_a;
        sb_a.push_back('{err: 2'b01, id: 64'h0});
        pulse_start_a();
        wait_done_a(400, seen);
        total++;
        if (!seen) begin
            bad++; $display("FAIL no_pres_done: got no done want done within 400 cycles");
        end else begin
            e = sb_a.pop_front();
            total++; if (bus_a.err !== e.err) begin bad++; $display("FAIL no_pres_err: got %b want %b", bus_a.err, e.err); end
            total++; if (bus_a.rom_id !== e.id) begin bad++; $display("FAIL no_pres_rom_id: got %h want %h", bus_a.rom_id, e.id); end
        end
        repeat (3) @(negedge clk);
        total++; if (rst_phases_a - rst_base !== 4) begin bad++; $display("FAIL no_pres_resets: got %0d want 4", rst_phases_a - rst_base); end
        total++; if (done_cnt_a - dn_base !== 1) begin bad++; $display("FAIL no_pres_done_count: got %0d want 1", done_cnt_a - dn_base); end
        $display("no_presence: err=%b rom_id=%h resets=%0d", bus_a.err, bus_a.rom_id, rst_phases_a - rst_base);
        pres_a = 1'b1;
    endtask

    task automatic test_crc_retry();
        bit   seen;
        int   rst_base;
        exp_t e;
        rom_first_a = ROM_BAD;
        rom_rest_a  = ROM_GOOD;
        rom_base_a  = rom_reads_a;
        rst_base    = rst_phases_a;
        sb_a.push_back('{err: 2'b00, id: ROM_GOOD});
        pulse_start_a();
        wait_done_a(400, seen);
        total++;
        if (!seen) begin
            bad++; $display("FAIL crc_retry_done: got no done want done within 400 cycles");
        end else begin
            e = sb_a.pop_front();
            total++; if (bus_a.err !== e.err) begin bad++; $display("FAIL crc_retry_err: got %b want %b", bus_a.err, e.err); end
            total++; if (bus_a.rom_id !== e.id) begin bad++; $display("FAIL crc_retry_rom_id: got %h want %h", bus_a.rom_id, e.id); end
        end
        repeat (2) @(negedge clk);
        total++; if (rst_phases_a - rst_base !== 2) begin bad++; $display("FAIL crc_retry_attempts: got %0d want 2", rst_phases_a - rst_base); end
        $display("crc_retry: err=%b rom_id=%h attempts=%0d", bus_a.err, bus_a.rom_id, rst_phases_a - rst_base);
        rom_first_a = ROM_GOOD;
    endtask

    task automatic test_happy();
        bit         seen;
        int         log_base;
        exp_t       e;
        logic [2:0] exp_cmds[6];
        exp_cmds = '{CMD_RESET, CMD_IDLE, CMD_PRES, CMD_IDLE, CMD_READ_ROM, CMD_IDLE};
        log_base = cmd_log_a.size();
        sb_a.push_back('{err: 2'b00, id: ROM_GOOD});
        pulse_start_a();
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL happy_busy: got %b want 1", bus_a.busy); end
        wait_done_a(400, seen);
        total++;
        if (!seen) begin
            bad++; $display("FAIL happy_done: got no done want done within 400 cycles");
        end else begin
            e = sb_a.pop_front();
            total++; if (bus_a.err !== e.err) begin bad++; $display("FAIL happy_err: got %b want %b", bus_a.err, e.err); end
            total++; if (bus_a.rom_id !== e.id) begin bad++; $display("FAIL happy_rom_id: got %h want %h", bus_a.rom_id, e.id); end
            total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL happy_busy_at_done: got %b want 0", bus_a.busy); end
            @(negedge clk);
            total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL happy_done_width: got %b want 0", bus_a.done); end
        end
        total++; if (cmd_log_a.size() - log_base !== 6) begin bad++; $display("FAIL happy_cmd_count: got %0d want 6", cmd_log_a.size() - log_base); end
        for (int i = 0; i < 6; i++) begin
            if (log_base + i < cmd_log_a.size()) begin
                total++;
                if (cmd_log_a[log_base + i] !== exp_cmds[i]) begin
                    bad++; $display("FAIL happy_cmd_%0d: got %b want %b", i, cmd_log_a[log_base + i], exp_cmds[i]);
                end
            end
        end
        $display("happy: err=%b rom_id=%h cmd_changes=%0d", bus_a.err, bus_a.rom_id, cmd_log_a.size() - log_base);
    endtask

    task automatic test_back_to_back();
        bit   seen;
        int   rst_base, dn_base;
        exp_t e;
        rst_base = rst_phases_a;
        dn_base  = done_cnt_a;
        sb_a.push_back('{err: 2'b00, id: ROM_GOOD});
        pulse_start_a();
        repeat (2) @(negedge clk);
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_mid: got %b want 1", bus_a.busy); end
        pulse_start_a();
        wait_done_a(400, seen);
        total++;
        if (!seen) begin
            bad++; $display("FAIL b2b_done: got no done want done within 400 cycles");
        end else begin
            bus_a.start = 1'b1;
            e = sb_a.pop_front();
            total++; if (bus_a.err !== e.err) begin bad++; $display("FAIL b2b_err: got %b want %b", bus_a.err, e.err); end
            @(negedge clk);
            bus_a.start = 1'b0;
        end
        repeat (10) @(negedge clk);
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_after: got %b want 0", bus_a.busy); end
        total++; if (rst_phases_a - rst_base !== 1) begin bad++; $display("FAIL b2b_resets: got %0d want 1", rst_phases_a - rst_base); end
        total++; if (done_cnt_a - dn_base !== 1) begin bad++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt_a - dn_base); end
        $display("back_to_back: resets=%0d dones=%0d busy=%b", rst_phases_a - rst_base, done_cnt_a - dn_base, bus_a.busy);
    endtask

    task automatic test_timeout();
        bit   seen;
        int   cycles;
        exp_t e;
        hang_b = 1'b1;
        sb_b.push_back('{err: 2'b11, id: 64'h0});
        pulse_start_b();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_b.m_cmd === CMD_READ_ROM) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL timeout_rom_entry: got no READ_ROM want READ_ROM within 100 cycles");
        end else begin
            cycles = -1;
            for (int k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (bus_b.done === 1'b1) begin
                    cycles = k;
                    break;
                end
            end
            total++; if (cycles !== 16) begin bad++; $display("FAIL timeout_latency: got %0d want 16", cycles); end
            if (cycles > 0) begin
                e = sb_b.pop_front();
                total++; if (bus_b.err !== e.err) begin bad++; $display("FAIL timeout_err: got %b want %b", bus_b.err, e.err); end
                total++; if (bus_b.rom_id !== e.id) begin bad++; $display("FAIL timeout_rom_id: got %h want %h", bus_b.rom_id, e.id); end
                total++; if (bus_b.m_cmd !== CMD_IDLE) begin bad++; $display("FAIL timeout_m_cmd: got %b want 000", bus_b.m_cmd); end
            end
            $display("timeout: cycles=%0d err=%b m_cmd=%b", cycles, bus_b.err, bus_b.m_cmd);
        end
        hang_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit   seen;
        int   rst_base;
        exp_t e;
        pulse_start_a();
        wait_cmd_a(CMD_READ_ROM, 100, seen);
        total++;
        if (!seen) begin
            bad++; $display("FAIL areset_rom_entry: got no READ_ROM want READ_ROM within 100 cycles");
        end
        wait_cmd_a(CMD_IDLE, 100, seen);
        repeat (20) @(negedge clk);
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL areset_busy_before: got %b want 1", bus_a.busy); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b want 0", bus_a.busy); end
        total++; if (bus_a.m_cmd !== 3'b000) begin bad++; $display("FAIL areset_m_cmd: got %b want 000", bus_a.m_cmd); end
        total++; if (bus_a.rom_id !== 64'h0) begin bad++; $display("FAIL areset_rom_id: got %h want 0", bus_a.rom_id); end
        $display("async_reset: busy=%b m_cmd=%b rom_id=%h", bus_a.busy, bus_a.m_cmd, bus_a.rom_id);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        rst_base = rst_phases_a;
        sb_a.push_back('{err: 2'b00, id: ROM_GOOD});
        pulse_start_a();
        wait_done_a(400, seen);
        total++;
        if (!seen) begin
            bad++; $display("FAIL areset_rerun_done: got no done want done within 400 cycles");
        end else begin
            e = sb_a.pop_front();
            total++; if (bus_a.err !== e.err) begin bad++; $display("FAIL areset_rerun_err: got %b want %b", bus_a.err, e.err); end
            total++; if (bus_a.rom_id !== e.id) begin bad++; $display("FAIL areset_rerun_rom_id: got %h want %h", bus_a.rom_id, e.id); end
        end
        repeat (2) @(negedge clk);
        total++; if (rst_phases_a - rst_base !== 1) begin bad++; $display("FAIL areset_rerun_resets: got %0d want 1", rst_phases_a - rst_base); end
        $display("async_reset rerun: err=%b rom_id=%h", bus_a.err, bus_a.rom_id);
    endtask

    initial begin
        test_reset();
        test_no_presence();
        test_crc_retry();
        test_happy();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        total++;
        if (sb_a.size() + sb_b.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb_a.size() + sb_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/onewire_seq_ctrl.md
Name: onewire_seq_ctrl

Overview:
Bus-sequencing controller for the 1-Wire master (master_top). On a single start pulse it drives the master's cmd/data_in interface through RESET, PRESENCE and READ_ROM. It checks the returned 64-bit ROM with a Dallas CRC-8 and retries failed attempts. It presents a start/done handshake plus an error code to the host logic, so no host block drives raw master commands.

Parameters:
- TIMEOUT_CYC, 4096, maximum clk cycles to wait for master done in any one phase.
- RETRIES, 3, extra full attempts after a failed attempt (no presence, CRC fail, timeout).
- CNT_W, 13, width of the phase timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle request to run the sequence; ignored unless busy=0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at sequence end, whether it succeeded or failed.
- err  out  2  valid with done: 00 ok, 01 no presence, 10 CRC fail, 11 timeout.
- rom_id  out  64  last ROM read with good CRC; family code in [7:0], CRC in [63:56].
- m_cmd  out  3  to master cmd: 000 IDLE, 010 RESET, 011 PRESENCE, 100 READ_ROM.
- m_din  out  8  to master data_in; held at 8'h00 (reserved for later write support).
- m_dout  in  64  master data_out; sampled in the cycle m_status[0]=1 during READ_ROM.
- m_status  in  8  master status: [0] phase done, [1] presence seen, other bits ignored.

Behaviour:
- Reset values: busy=0, done=0, err=00, rom_id=0, m_cmd=000, m_din=00, FSM=IDLE, retry count=0, timeout counter=0.
- FSM states: IDLE, RST, PRES, ROM, GAP, CRC, FIN.
- IDLE: when start=1, load retry count=RETRIES, set busy=1 and go to RST.
- RST, PRES, ROM: m_cmd holds that phase's code every cycle in the state. The timeout counter clears on state entry and increments each cycle.
- When m_status[0]=1, the phase ends. The FSM goes to GAP for exactly one cycle with m_cmd=000, so the master sees a command edge, then enters the next phase.
- Phase order is RST → PRES → ROM → CRC.
- PRES end with m_status[1]=0: attempt fails with code 01.
- ROM end: latch m_dout into an internal rom_buf, then go through GAP to CRC.
- CRC: the sub-module runs bytes 0..6 LSB-first, 8 cycles per byte (56 cycles total), then compares the result with rom_buf[63:56].
  - Match: rom_id ← rom_buf, code 00.
  - Mismatch: code 10.
- Timeout: if the counter reaches TIMEOUT_CYC-1 without a done in the current phase, the attempt fails with code 11.
- Failed attempt with retry count>0: decrement the count, m_cmd=000 for one GAP cycle, restart at RST.
- Failed attempt with retry count=0: go to FIN.
- FIN: done=1 and err=code for exactly one cycle; busy drops in the same cycle; return to IDLE.
- err holds its value until the next start is accepted, then clears to 00.
- start while busy=1 is ignored; no queuing.
- start in the same cycle as done: ignored (FSM is in FIN, not IDLE).
- m_status[0] already high on phase entry counts as done, to keep latency minimal. The master clears done on cmd=000, which the GAP state guarantees.
- rom_id is updated only on a CRC pass. A failed sequence leaves the previous ID intact.
- rst asserted mid-sequence: all outputs return to reset values immediately (asynchronously). m_cmd=000 releases the master.
- Latency with an ideal master (done one cycle after each command): start → done = 1 + 3 phases + 3 GAP + 56 CRC + 1 FIN cycles.

Decomposition:
- Package onewire_pkg:
  - Command constants CMD_IDLE=3'b000, CMD_RESET=3'b010, CMD_PRES=3'b011, CMD_READ_ROM=3'b100, CMD_SEND_ROM=3'b101.
  - Status bit indices ST_DONE=0, ST_PRES=1.
  - Error codes, the FSM state enum, and CRC polynomial constant 8'h8C (reflected form of x^8+x^5+x^4+1).
- Sub-module onewire_crc8: bit-serial Dallas CRC-8.
  - Ports: clk, rst, clr, en, bit_in, crc[7:0].
  - One bit per en cycle; clr zeroes crc and takes priority over en.

Test Plan:
- Happy path: behavioural master returns presence=1 and m_dout=64'hA200_0000_01B8_1C02 → err=00, rom_id=64'hA200000001B81C02, one done pulse, m_cmd sequence 010,000,011,000,100,000.
- No presence: m_status[1]=0 on every attempt with RETRIES=3 → exactly 4 RESET phases, then err=01 and rom_id unchanged (0).
- CRC fail then pass: first ROM read 64'hA300000001B81C02, second ROM read good → err=00 after 2 attempts, rom_id=64'hA200000001B81C02.
- Timeout: master never asserts done in ROM, TIMEOUT_CYC=16, RETRIES=0 → done with err=11 exactly 16 cycles after ROM entry, m_cmd back to 000.
- Start while busy, and start in the same cycle as done: both ignored. Only one sequence runs (count RESET phases = 1).
- rst pulled low in the middle of the CRC state → busy=0, m_cmd=000, rom_id=0 in the same cycle. The next start runs a clean full sequence.
